// File: rtl/inst_fetch_queue.sv
// Fetch byte queue feeding a 48-bit MIPS/Y86 window to decode.
// Define IFQ_BYPASS_EN to forward ack data straight to decode when empty.
`ifndef Y86_OP_HALT
`define Y86_OP_HALT   4'h0
`endif
`ifndef Y86_OP_NOP
`define Y86_OP_NOP    4'h1
`endif
`ifndef Y86_OP_RRMOVL
`define Y86_OP_RRMOVL 4'h2
`endif
`ifndef Y86_OP_IRMOVL
`define Y86_OP_IRMOVL 4'h3
`endif
`ifndef Y86_OP_RMMOVL
`define Y86_OP_RMMOVL 4'h4
`endif
`ifndef Y86_OP_MRMOVL
`define Y86_OP_MRMOVL 4'h5
`endif
`ifndef Y86_OP_OPL
`define Y86_OP_OPL    4'h6
`endif
`ifndef Y86_OP_JXX
`define Y86_OP_JXX    4'h7
`endif
`ifndef Y86_OP_CALL
`define Y86_OP_CALL   4'h8
`endif
`ifndef Y86_OP_RET
`define Y86_OP_RET    4'h9
`endif
`ifndef Y86_OP_PUSHL
`define Y86_OP_PUSHL  4'hA
`endif
`ifndef Y86_OP_POPL
`define Y86_OP_POPL   4'hB
`endif
`ifndef Y86_OP_IOPL
`define Y86_OP_IOPL   4'hC
`endif
`ifndef Y86_OP_OPIL
`define Y86_OP_OPIL   4'hD
`endif
`ifndef Y86_OP_JMIPS
`define Y86_OP_JMIPS  4'hE
`endif

module inst_fetch_queue #(
  parameter int          QBYTES   = 12,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [47:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] next_inst_pc,
  output logic [2:0]  inst_len,
  output logic        inst_valid,
  input  logic        consume
);
  localparam int CW = $clog2(QBYTES + 1) + 1;
  localparam int CB = QBYTES + 6;
  localparam int IW = $clog2(CB);
  localparam logic [CW-1:0] QMAX = CW'(QBYTES);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    q_q [QBYTES];
  logic [7:0]    q_d [QBYTES];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   faddr_q, faddr_d;
  logic [31:0]   raddr_q, raddr_d;
  logic [1:0]    skip_q, skip_d;

  logic [7:0]    cb  [CB];
  logic [7:0]    win [6];
  logic [31:0]   rsh;
  logic          app;
  logic          fits;
  logic [CW-1:0] app_n, ccnt, vcnt, pop, ncnt, room;
  logic [IW-1:0] idx;

  always_comb begin
    app   = (state_q == WAIT) && imem_ack && !redirect;
    app_n = app ? CW'(3'd4 - {1'b0, skip_q}) : '0;
    rsh   = imem_rdata >> {skip_q, 3'b000};
    idx   = '0;

    // queue bytes followed by this cycle's append, before the pop
    for (int j = 0; j < CB; j++) cb[j] = '0;
    for (int j = 0; j < QBYTES; j++)
      if (CW'(j) < cnt_q) cb[j] = q_q[j];
    for (int k = 0; k < 4; k++) begin
      idx = IW'(cnt_q) + IW'(k);
      if (CW'(k) < app_n) cb[idx] = rsh[8*k +: 8];
    end
    ccnt = cnt_q + app_n;

`ifdef IFQ_BYPASS_EN
    vcnt = (cnt_q == '0) ? ccnt : cnt_q;
`else
    vcnt = cnt_q;
`endif

    for (int j = 0; j < 6; j++)
      win[j] = (CW'(j) < vcnt) ? cb[j] : 8'h00;
    inst = {win[5], win[4], win[3], win[2], win[1], win[0]};

    inst_len = 3'd1;
    if (!mode) begin
      inst_len = 3'd4;
    end else if (vcnt != '0) begin
      unique case (win[0][7:4])
        `Y86_OP_RRMOVL, `Y86_OP_OPL,
        `Y86_OP_PUSHL, `Y86_OP_POPL:   inst_len = 3'd2;
        `Y86_OP_JXX, `Y86_OP_CALL,
        `Y86_OP_JMIPS:                 inst_len = 3'd5;
        `Y86_OP_IRMOVL, `Y86_OP_RMMOVL,
        `Y86_OP_MRMOVL, `Y86_OP_IOPL,
        `Y86_OP_OPIL:                  inst_len = 3'd6;
        default:                       inst_len = 3'd1;
      endcase
    end

    inst_valid   = (CW'(inst_len) <= vcnt) && !redirect;
    inst_pc      = pc_q;
    next_inst_pc = pc_q + 32'(inst_len);

    pop  = (inst_valid && consume) ? CW'(inst_len) : '0;
    ncnt = ccnt - pop;
    room = cnt_q - pop + CW'(4) - CW'(skip_q);
    fits = room <= QMAX;

    imem_req  = !reset && ((state_q != IDLE) || (fits && !redirect));
    imem_addr = (state_q == IDLE) ? faddr_q : raddr_q;

    for (int j = 0; j < QBYTES; j++) begin
      idx    = IW'(j) + IW'(pop);
      q_d[j] = cb[idx];
    end

    state_d = state_q;
    cnt_d   = ncnt;
    pc_d    = pc_q + 32'(pop);
    faddr_d = faddr_q;
    raddr_d = raddr_q;
    skip_d  = skip_q;

    if (redirect) begin
      cnt_d   = '0;
      pc_d    = redirect_pc;
      faddr_d = {redirect_pc[31:2], 2'b00};
      skip_d  = redirect_pc[1:0];
    end

    unique case (state_q)
      IDLE: begin
        if (!redirect && fits) begin
          state_d = WAIT;
          raddr_d = faddr_q;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          if (redirect) begin
            state_d = IDLE;
          end else begin
            faddr_d = faddr_q + 32'd4;
            skip_d  = '0;
            if (ncnt + CW'(4) <= QMAX) raddr_d = faddr_q + 32'd4;
            else                       state_d = IDLE;
          end
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      faddr_q <= {RESET_PC[31:2], 2'b00};
      raddr_q <= {RESET_PC[31:2], 2'b00};
      skip_q  <= RESET_PC[1:0];
      for (int j = 0; j < QBYTES; j++) q_q[j] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      faddr_q <= faddr_d;
      raddr_q <= raddr_d;
      skip_q  <= skip_d;
      for (int j = 0; j < QBYTES; j++) q_q[j] <= q_d[j];
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random
// traffic checked against a byte-queue reference model.
module tb_inst_fetch_queue;
  localparam int Q = 12;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, mode, redirect, consume;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [47:0] inst;
  logic [31:0] inst_pc, next_inst_pc;
  logic [2:0]  inst_len;
  logic        inst_valid;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.QBYTES(Q), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc),
    .next_inst_pc(next_inst_pc), .inst_len(inst_len),
    .inst_valid(inst_valid), .consume(consume)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; mode = 0; redirect = 0; redirect_pc = 0;
    imem_ack = 0; imem_rdata = 0; consume = 0;
    tick(); tick();
    reset = 0;
  endtask

  function automatic int ylen(logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h9:        return 1;
      4'h2, 4'h6, 4'hA, 4'hB:  return 2;
      4'h7, 4'h8, 4'hE:        return 5;
      4'h3, 4'h4, 4'h5,
      4'hC, 4'hD:              return 6;
      default:                 return 1;
    endcase
  endfunction

  function automatic logic [31:0] memfn(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A1234;
  endfunction

  task automatic test_reset();
    reset = 1; mode = 0; redirect = 0; redirect_pc = 0;
    imem_ack = 0; imem_rdata = 0; consume = 0;
    tick(); tick(); #1;
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req got %b want 0", imem_req); end
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", inst_valid); end
    vecs++; if (inst !== 48'h0) begin errs++; $display("FAIL rst_inst got %h want 0", inst); end
    vecs++; if (inst_pc !== 32'h0) begin errs++; $display("FAIL rst_pc got %h want 0", inst_pc); end
    reset = 0; #1;
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL rst_req1 got %b want 1", imem_req); end
    vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL rst_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_basic();
    do_reset(); tick();
    imem_ack = 1; imem_rdata = 32'h20080005; #1;
    vecs++; if (inst_valid !== BYP) begin errs++; $display("FAIL basic_ackcyc got %b want %b", inst_valid, BYP); end
    tick(); imem_ack = 0; #1;
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %b want 1", inst_valid); end
    vecs++; if (inst[31:0] !== 32'h20080005) begin errs++; $display("FAIL basic_inst got %h want 20080005", inst[31:0]); end
    vecs++; if (inst_len !== 3'd4) begin errs++; $display("FAIL basic_len got %0d want 4", inst_len); end
    vecs++; if (next_inst_pc !== 32'h4) begin errs++; $display("FAIL basic_npc got %h want 4", next_inst_pc); end
  endtask

  task automatic test_skip();
    do_reset();
    mode = 1; redirect = 1; redirect_pc = 32'h102; #1;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL skip_redir_valid got %b want 0", inst_valid); end
    tick(); redirect = 0; #1;
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL skip_req got %b want 1", imem_req); end
    vecs++; if (imem_addr !== 32'h100) begin errs++; $display("FAIL skip_addr got %h want 100", imem_addr); end
    tick(); imem_ack = 1; imem_rdata = 32'hF830_0000;
    tick(); imem_ack = 0; #1;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL skip_partial got %b want 0", inst_valid); end
    vecs++; if (inst_len !== 3'd6) begin errs++; $display("FAIL skip_len got %0d want 6", inst_len); end
    vecs++; if (imem_addr !== 32'h104) begin errs++; $display("FAIL skip_addr2 got %h want 104", imem_addr); end
    imem_ack = 1; imem_rdata = 32'h0000_0064;
    tick(); imem_ack = 0; #1;
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL skip_valid got %b want 1", inst_valid); end
    vecs++; if (inst_pc !== 32'h102) begin errs++; $display("FAIL skip_pc got %h want 102", inst_pc); end
    vecs++; if (inst !== 48'h0000_0064_F830) begin errs++; $display("FAIL skip_inst got %h want 00000064f830", inst); end
    vecs++; if (next_inst_pc !== 32'h108) begin errs++; $display("FAIL skip_npc got %h want 108", next_inst_pc); end
  endtask

  task automatic test_y86_stream();
    int pcs [3] = '{0, 1, 3};
    int lens[3] = '{1, 2, 1};
    do_reset();
    mode = 1; redirect = 1; redirect_pc = 32'h0;
    tick(); redirect = 0;
    tick(); imem_ack = 1; imem_rdata = 32'h90122010;
    tick(); imem_ack = 0; consume = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL y86_valid%0d got %b want 1", i, inst_valid); end
      vecs++; if (inst_pc !== 32'(pcs[i])) begin errs++; $display("FAIL y86_pc%0d got %h want %h", i, inst_pc, pcs[i]); end
      vecs++; if (inst_len !== 3'(lens[i])) begin errs++; $display("FAIL y86_len%0d got %0d want %0d", i, inst_len, lens[i]); end
      tick();
    end
    #1;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL y86_empty got %b want 0", inst_valid); end
    consume = 0;
  endtask

  task automatic test_redirect_drop();
    do_reset(); tick();
    imem_ack = 1; imem_rdata = 32'h11111111; tick();
    imem_rdata = 32'h22222222; tick();
    imem_ack = 0; redirect = 1; redirect_pc = 32'h40; #1;
    vecs++; if (imem_addr !== 32'h8) begin errs++; $display("FAIL drop_addr0 got %h want 8", imem_addr); end
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL drop_valid0 got %b want 0", inst_valid); end
    tick(); redirect = 0;
    repeat (2) begin
      #1;
      vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errs++; $display("FAIL drop_hold got %b/%h want 1/8", imem_req, imem_addr); end
      vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL drop_valid got %b want 0", inst_valid); end
      tick();
    end
    imem_ack = 1; imem_rdata = 32'hDEADBEEF; #1;
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL drop_ackcyc got %b want 0", inst_valid); end
    tick(); imem_ack = 0; #1;
    vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errs++; $display("FAIL drop_newreq got %b/%h want 1/40", imem_req, imem_addr); end
    vecs++; if (inst_valid !== 1'b0) begin errs++; $display("FAIL drop_discard got %b want 0", inst_valid); end
    tick(); #1;
    imem_ack = 1; imem_rdata = 32'h44332211;
    tick(); imem_ack = 0; #1;
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL drop_fill got %b want 1", inst_valid); end
    vecs++; if (inst_pc !== 32'h40) begin errs++; $display("FAIL drop_pc got %h want 40", inst_pc); end
    vecs++; if (inst[31:0] !== 32'h44332211) begin errs++; $display("FAIL drop_inst got %h want 44332211", inst[31:0]); end
  endtask

  task automatic test_full();
    logic [31:0] w[3];
    do_reset(); tick();
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom; imem_ack = 1; imem_rdata = w[i]; tick();
    end
    imem_ack = 0; #1;
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL full_req got %b want 0", imem_req); end
    vecs++; if (inst[31:0] !== w[0]) begin errs++; $display("FAIL full_inst0 got %h want %h", inst[31:0], w[0]); end
    tick(); #1;
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL full_req2 got %b want 0", imem_req); end
    consume = 1; #1;
    vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errs++; $display("FAIL full_rereq got %b/%h want 1/c", imem_req, imem_addr); end
    tick(); consume = 0; #1;
    vecs++; if (inst_pc !== 32'h4) begin errs++; $display("FAIL full_pc got %h want 4", inst_pc); end
    vecs++; if (inst[31:0] !== w[1]) begin errs++; $display("FAIL full_inst1 got %h want %h", inst[31:0], w[1]); end
  endtask

  task automatic test_latency();
    do_reset();
    mode = 1; redirect = 1; redirect_pc = 32'h0;
    tick(); redirect = 0;
    tick(); imem_ack = 1; imem_rdata = 32'h00000010; #1;
    vecs++; if (inst_valid !== BYP) begin errs++; $display("FAIL lat_ackcyc got %b want %b", inst_valid, BYP); end
    tick(); imem_ack = 0; #1;
    vecs++; if (inst_valid !== 1'b1) begin errs++; $display("FAIL lat_valid got %b want 1", inst_valid); end
    vecs++; if (inst_len !== 3'd1) begin errs++; $display("FAIL lat_len got %0d want 1", inst_len); end
  endtask

  task automatic test_random(int ncyc);
    logic [7:0]  bq[$];
    logic [7:0]  view[$];
    logic [31:0] m_pc = 0, m_fa = 0, m_ra = 0, e_addr;
    logic [1:0]  m_sk = 0;
    bit          m_out = 0, m_drop = 0, busy = 0, was, appd;
    bit          e_valid, e_req;
    int          lat = 0, e_len, pop, room;
    logic [47:0] e_inst;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      redirect = ($urandom_range(0, 39) == 0);
      if (redirect) begin
        mode = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFFFFF4 + 32'($urandom_range(0, 11));
        else                           redirect_pc = 32'($urandom_range(0, 255));
      end
      consume = ($urandom_range(0, 3) < (((c / 200) % 2) ? 1 : 3));
      imem_ack = busy && (lat == 0);
      if (busy && lat > 0) lat--;
      imem_rdata = imem_ack ? memfn(imem_addr) : $urandom;
      #1;

      view = bq;
      if (BYP && bq.size() == 0 && m_out && !m_drop && imem_ack && !redirect)
        for (int k = int'(m_sk); k < 4; k++) view.push_back(imem_rdata[8*k +: 8]);
      if (!mode)                e_len = 4;
      else if (view.size() == 0) e_len = 1;
      else                      e_len = ylen(view[0][7:4]);
      e_valid = (view.size() >= e_len) && !redirect;
      e_inst = '0;
      for (int j = 0; j < 6; j++)
        if (j < view.size()) e_inst[8*j +: 8] = view[j];
      pop    = (e_valid && consume) ? e_len : 0;
      room   = bq.size() - pop + 4 - int'(m_sk);
      e_req  = m_out || (!redirect && room <= Q);
      e_addr = m_out ? m_ra : m_fa;

      vecs++; if (imem_req !== e_req) begin errs++; $display("FAIL rnd_req c%0d got %b want %b", c, imem_req, e_req); end
      if (e_req) begin
        vecs++; if (imem_addr !== e_addr) begin errs++; $display("FAIL rnd_addr c%0d got %h want %h", c, imem_addr, e_addr); end
      end
      vecs++; if (inst_valid !== e_valid) begin errs++; $display("FAIL rnd_valid c%0d got %b want %b", c, inst_valid, e_valid); end
      vecs++; if (inst_len !== 3'(e_len)) begin errs++; $display("FAIL rnd_len c%0d got %0d want %0d", c, inst_len, e_len); end
      vecs++; if (inst_pc !== m_pc) begin errs++; $display("FAIL rnd_pc c%0d got %h want %h", c, inst_pc, m_pc); end
      vecs++; if (next_inst_pc !== m_pc + 32'(e_len)) begin errs++; $display("FAIL rnd_npc c%0d got %h want %h", c, next_inst_pc, m_pc + 32'(e_len)); end
      vecs++; if (inst !== e_inst) begin errs++; $display("FAIL rnd_inst c%0d got %h want %h", c, inst, e_inst); end

      if (imem_ack)                  busy = 0;
      else if (imem_req && !busy) begin busy = 1; lat = $urandom_range(0, 2); end

      was = m_out;
      if (redirect) begin
        bq.delete();
        m_pc = redirect_pc;
        m_fa = {redirect_pc[31:2], 2'b00};
        m_sk = redirect_pc[1:0];
        if (m_out && imem_ack) begin m_out = 0; m_drop = 0; end
        else if (m_out)        m_drop = 1;
      end else begin
        appd = 0;
        if (m_out && imem_ack) begin
          if (m_drop) begin
            m_out = 0; m_drop = 0;
          end else begin
            for (int k = int'(m_sk); k < 4; k++) bq.push_back(imem_rdata[8*k +: 8]);
            m_fa = m_fa + 32'd4; m_sk = 0; appd = 1;
          end
        end
        for (int p = 0; p < pop; p++) void'(bq.pop_front());
        m_pc = m_pc + 32'(pop);
        if (appd) begin
          m_out = (bq.size() + 4 <= Q);
          m_ra  = m_fa;
        end else if (!was && e_req) begin
          m_out = 1;
          m_ra  = m_fa;
        end
      end
      tick();
    end
    redirect = 0; consume = 0; imem_ack = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_y86_stream();
    test_redirect_drop();
    test_full();
    test_latency();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
